// File: rtl/fp_mult_sequencer_if.sv
// Request/response bundle between the issuing logic and the sequential FP multiplier.
// The issuer drives the master side; the multiplier sits on the slave side.
interface fp_mult_sequencer_if #(
  parameter int unsigned EXP_WIDTH      = 8,
  parameter int unsigned MANTISSA_WIDTH = 23
) ();
  localparam int unsigned W = EXP_WIDTH + MANTISSA_WIDTH + 1;

  logic         start_in;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         busy_out;
  logic         done_out;
  logic [W-1:0] result_out;
  logic         overflow_out;
  logic         underflow_out;

  modport master (
    output start_in, a_in, b_in,
    input  busy_out, done_out, result_out, overflow_out, underflow_out
  );

  modport slave (
    input  start_in, a_in, b_in,
    output busy_out, done_out, result_out, overflow_out, underflow_out
  );
endinterface

// File: rtl/fp_mult_sequencer.sv
// Sequential FP multiplier: shift-add mantissa product one multiplier bit per cycle,
// followed by truncating normalization, range check and packing.
module fp_mult_sequencer #(
  parameter int unsigned EXP_WIDTH      = 8,
  parameter int unsigned MANTISSA_WIDTH = 23
) (
  input logic                clk_in,
  input logic                rst_n_in,
  fp_mult_sequencer_if.slave bus
);
  localparam int unsigned Bias   = 2**(EXP_WIDTH-1) - 1;
  localparam int unsigned W      = EXP_WIDTH + MANTISSA_WIDTH + 1;
  localparam int unsigned MW     = MANTISSA_WIDTH + 1;
  localparam int unsigned PW     = 2 * MW;
  localparam int unsigned SW     = EXP_WIDTH + 2;
  localparam int unsigned CntW   = $clog2(MW + 1);
  localparam int unsigned ExpMax = 2**EXP_WIDTH - 1;

  typedef enum logic [2:0] {StIdle, StUnpack, StMult, StNorm, StDone} state_e;

  state_e              state_q;
  logic [W-1:0]        a_q, b_q;
  logic                sign_q, zero_q;
  logic [MW-1:0]       ma_q, mb_q;
  logic [SW-1:0]       esum_q;
  logic [PW-1:0]       acc_q;
  logic [CntW-1:0]     cnt_q;
  logic                busy_q, done_q, ovf_q, unf_q;
  logic [W-1:0]        result_q;

  logic [EXP_WIDTH-1:0]      ea, eb;
  logic [SW-1:0]             esum_calc;
  logic                      norm_hi;
  logic [MANTISSA_WIDTH-1:0] frac_n;
  logic [SW-1:0]             e_n;
  logic                      exp_big, exp_small;
  logic [W-1:0]              res_n;
  logic                      ovf_n, unf_n;
  logic                      unused_acc_lo;

  assign ea        = a_q[W-2:MANTISSA_WIDTH];
  assign eb        = b_q[W-2:MANTISSA_WIDTH];
  // Two's-complement in SW bits, so a negative biased sum shows up in the top bit.
  assign esum_calc = SW'(ea) + SW'(eb) - SW'(Bias);

  assign norm_hi   = acc_q[PW-1];
  assign frac_n    = norm_hi ? acc_q[PW-2 -: MANTISSA_WIDTH] : acc_q[PW-3 -: MANTISSA_WIDTH];
  assign e_n       = norm_hi ? esum_q + SW'(1) : esum_q;
  assign exp_big   = !e_n[SW-1] && (e_n >= SW'(ExpMax));
  assign exp_small = e_n[SW-1] || (e_n == '0);
  // Truncation discards the low product bits.
  assign unused_acc_lo = ^acc_q[MANTISSA_WIDTH-1:0];

  always_comb begin
    res_n = '0;
    ovf_n = 1'b0;
    unf_n = 1'b0;
    if (zero_q) begin
      res_n = {sign_q, (W-1)'(0)};
    end else if (exp_big) begin
      res_n = {sign_q, {EXP_WIDTH{1'b1}}, {MANTISSA_WIDTH{1'b0}}};
      ovf_n = 1'b1;
    end else if (exp_small) begin
      res_n = {sign_q, (W-1)'(0)};
      unf_n = 1'b1;
    end else begin
      res_n = {sign_q, e_n[EXP_WIDTH-1:0], frac_n};
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      sign_q   <= 1'b0;
      zero_q   <= 1'b0;
      ma_q     <= '0;
      mb_q     <= '0;
      esum_q   <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      result_q <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.start_in) begin
            a_q     <= bus.a_in;
            b_q     <= bus.b_in;
            busy_q  <= 1'b1;
            state_q <= StUnpack;
          end
        end
        StUnpack: begin
          sign_q  <= a_q[W-1] ^ b_q[W-1];
          ma_q    <= {1'b1, a_q[MANTISSA_WIDTH-1:0]};
          mb_q    <= {1'b1, b_q[MANTISSA_WIDTH-1:0]};
          esum_q  <= esum_calc;
          acc_q   <= '0;
          cnt_q   <= '0;
          // Denormals are flushed, so any zero exponent means a zero operand.
          zero_q  <= (ea == '0) || (eb == '0);
          state_q <= ((ea == '0) || (eb == '0)) ? StNorm : StMult;
        end
        StMult: begin
          if (mb_q[cnt_q]) begin
            acc_q <= acc_q + (PW'(ma_q) << cnt_q);
          end
          cnt_q <= cnt_q + CntW'(1);
          if (cnt_q == CntW'(MANTISSA_WIDTH)) begin
            state_q <= StNorm;
          end
        end
        StNorm: begin
          result_q <= res_n;
          ovf_q    <= ovf_n;
          unf_q    <= unf_n;
          done_q   <= 1'b1;
          state_q  <= StDone;
        end
        StDone: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.busy_out      = busy_q;
  assign bus.done_out      = done_q;
  assign bus.result_out    = result_q;
  assign bus.overflow_out  = ovf_q;
  assign bus.underflow_out = unf_q;
endmodule

// File: doc/fp_mult_sequencer.md
Name: fp_mult_sequencer

Overview:
Multi-cycle floating-point multiplier controller. It captures two packed operands on a start strobe and unpacks them. It runs an iterative shift-add mantissa multiply, one multiplier bit per cycle, then normalizes, checks range and packs the result. It pulses done when finished. It sits between the issuing logic and the FP result register, and replaces the single-cycle combinational multiply/normalize path where area matters more than latency.

Parameters:
- EXP_WIDTH, 8, exponent field width.
- MANTISSA_WIDTH, 23, stored fraction width; the hidden bit is added internally.
- Derived BIAS = 2**(EXP_WIDTH-1)-1.
- Derived W = EXP_WIDTH+MANTISSA_WIDTH+1, the packed operand width.

Ports:
- clk_in  input  1  clock, rising edge
- rst_n_in  input  1  asynchronous active-low reset
- start_in  input  1  request; sampled only in IDLE
- a_in  input  W  operand A {sign, exp, frac}
- b_in  input  W  operand B
- busy_out  output  1  high in every state except IDLE
- done_out  output  1  one-cycle pulse, high exactly while in DONE
- result_out  output  W  packed product; registered; held until the next accepted start
- overflow_out  output  1  registered flag, valid with done_out, held with result_out
- underflow_out  output  1  registered flag, valid with done_out, held with result_out

Behaviour:
- One clock, clk_in. Reset is asynchronous and active-low on rst_n_in.
- Reset, including mid-operation: state=IDLE; busy_out, done_out, overflow_out, underflow_out all 0; result_out=0; internal accumulator, counter and operand registers cleared. No done pulse follows a reset.
- States and transitions:
  - IDLE -> UNPACK on start_in=1. This edge (t0) captures a_in and b_in.
  - UNPACK -> MULT normally. UNPACK -> NORM when either operand has exp==0 (zero; denormals are flushed).
  - MULT -> NORM after exactly MANTISSA_WIDTH+1 iterations.
  - NORM -> DONE.
  - DONE -> IDLE unconditionally.
- start_in is ignored in every state except IDLE. Captured operands do not change while busy.
- UNPACK: sign = sa^sb. ma = {1,fa}, mb = {1,fb}. esum = ea+eb-BIAS, computed signed in EXP_WIDTH+2 bits. acc = 0. cnt = 0.
- MULT, each cycle: if mb[cnt], acc += ma<<cnt; then cnt++. acc is 2*(MANTISSA_WIDTH+1) bits wide and cannot overflow.
- NORM:
  - If acc[2M+1] (M = MANTISSA_WIDTH): frac = acc[2M:M+1], e = esum+1.
  - Else: frac = acc[2M-1:M], e = esum.
  - Truncate; there is no rounding.
- NORM range check, in priority order:
  1. Zero path: result {sign,0,0}, both flags 0.
  2. e >= 2**EXP_WIDTH-1: result {sign, all-ones, 0}, overflow_out=1.
  3. e <= 0: result {sign,0,0}, underflow_out=1.
  4. Otherwise: result {sign, e[EXP_WIDTH-1:0], frac}, flags 0.
- Exp-all-ones inputs (inf/NaN) get no special handling beyond the rules above. Zero takes priority.
- result_out and the flags load on the NORM->DONE edge.
- Latency, counting edges after t0:
  - Normal path: done_out high after edge t0+MANTISSA_WIDTH+3 (t0+26 for defaults).
  - Zero path: done_out high after edge t0+2.
  - The next start is accepted one cycle after done_out, in IDLE.
- busy_out is high from after t0 through the DONE cycle, inclusive.

Test Plan:
- a=0x3FC00000 (1.5), b=0x40000000 (2.0), start at t0 -> done_out high only in cycle t0+26; result 0x40400000; flags 0; busy_out high for cycles t0+1..t0+26.
- a=0x3FC00000, b=0x3FC00000 (normalize-shift path) -> result 0x40100000 (2.25). Then a=0xC0000000 (-2), b=0x40400000 (3) -> result 0xC0C00000.
- a=0x00000000, b=0x40000000 -> done_out at t0+2; result 0x00000000; flags 0. Repeat with a=0x80000000 -> result 0x80000000.
- a=0x7F000000, b=0x40000000 -> result 0x7F800000, overflow_out=1, underflow_out=0. Then a=0x00800000, b=0x3F000000 -> result 0x00000000, underflow_out=1.
- Second start_in at t0+5 with different operands -> ignored; the first result is unchanged at t0+26. Hold start_in high through DONE -> a new operation begins on the IDLE edge.
- rst_n_in low asynchronously at t0+10 (mid-MULT) -> busy_out, done_out and result_out go to 0 immediately with no clock; no done pulse afterwards. A fresh start after release gives a correct result.
